fs_move_ctrl: RTL and testbench

Move sequencer for the 16×16 five-in-a-row board. It owns the shared cursor and decodes the shared player buttons. It arbitrates each placement against the board RAM in three steps: read the cell for occupancy, write the active player's stone, then hand off to the win checker. It sits between the debounced button inputs, the board memory, and the five-in-a-row checker, and sequences all three.

---
 rtl/fs_pkg.sv | 30 +++
 rtl/fs_edge_det.sv | 25 ++
 rtl/fs_move_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_fs_move_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fs_pkg.sv
// Shared types and constants for the five-in-a-row move sequencer.
// Cell and winner encodings match the board RAM and display logic.
package fs_pkg;

  localparam int FS_COORD_W = 4;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EVAL,
    S_WRITE,
    S_CHECK,
    S_OVER,
    S_CLEAR
  } state_t;

  function automatic logic [1:0] stone(input logic t);
    return t ? CELL_P2 : CELL_P1;
  endfunction

endpackage

// File: rtl/fs_edge_det.sv
// Rising-edge detector for a clk-synchronous button level.
// The level is registered once, so the edge appears a cycle after it rises.
module fs_edge_det (
  input  logic clk,
  input  logic resetn,
  input  logic i_lvl,
  output logic o_rise
);

  logic r_smp;
  logic r_prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_smp  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_smp  <= i_lvl;
      r_prev <= r_smp;
    end
  end

  assign o_rise = r_smp & ~r_prev;

endmodule

// File: rtl/fs_move_ctrl.sv
// Move sequencer: cursor, button decode, read-check-write placement,
// win-checker handoff and new-game clearing for the five-in-a-row board.
module fs_move_ctrl
  import fs_pkg::*;
#(
  parameter int COORD_W = FS_COORD_W,
  parameter int CELLS   = 1 << (2 * COORD_W)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 btn_x,
  input  logic                 btn_y,
  input  logic                 btn_place,
  input  logic                 new_game,
  output logic [2*COORD_W-1:0] loca,
  output logic [2*COORD_W-1:0] rd_addr,
  input  logic [1:0]           rd_data,
  output logic                 wr_en,
  output logic [2*COORD_W-1:0] wr_addr,
  output logic [1:0]           wr_data,
  output logic                 clr_req,
  input  logic                 clr_done,
  output logic                 chk_start,
  input  logic                 chk_done,
  input  logic                 chk_win,
  output logic                 turn,
  output logic                 illegal,
  output logic                 busy,
  output logic                 game_over,
  output logic [1:0]           winner
);

  localparam int AW = 2 * COORD_W;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LP_CELLS = CW'(CELLS);

  state_t             r_state;
  state_t             w_nxt;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_turn;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_win;
  logic               r_chk_first;

  logic w_ex;
  logic w_ey;
  logic w_ep;
  logic w_step_x;
  logic w_step_y;
  logic w_inc;
  logic w_toggle;
  logic w_set_win;
  logic [1:0] w_win_val;
  logic w_clr_fin;

  fs_edge_det u_ed_x (
    .clk    (clk),
    .resetn (resetn),
    .i_lvl  (btn_x),
    .o_rise (w_ex)
  );

  fs_edge_det u_ed_y (
    .clk    (clk),
    .resetn (resetn),
    .i_lvl  (btn_y),
    .o_rise (w_ey)
  );

  fs_edge_det u_ed_p (
    .clk    (clk),
    .resetn (resetn),
    .i_lvl  (btn_place),
    .o_rise (w_ep)
  );

  always_comb begin
    w_nxt     = r_state;
    w_step_x  = 1'b0;
    w_step_y  = 1'b0;
    w_inc     = 1'b0;
    w_toggle  = 1'b0;
    w_set_win = 1'b0;
    w_win_val = WIN_NONE;
    w_clr_fin = 1'b0;
    wr_en     = 1'b0;
    chk_start = 1'b0;
    illegal   = 1'b0;
    // new_game preempts everything, including a write due this cycle
    if (new_game) begin
      w_nxt = S_CLEAR;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_ep) begin
            w_nxt = S_READ;
          end else begin
            w_step_x = w_ex;
            w_step_y = w_ey;
          end
        end
        S_READ: w_nxt = S_EVAL;
        S_EVAL: begin
          if (rd_data != CELL_EMPTY) begin
            illegal = 1'b1;
            w_nxt   = S_IDLE;
          end else begin
            w_nxt = S_WRITE;
          end
        end
        S_WRITE: begin
          wr_en = 1'b1;
          w_inc = 1'b1;
          w_nxt = S_CHECK;
        end
        S_CHECK: begin
          chk_start = r_chk_first;
          if (chk_done) begin
            if (chk_win) begin
              w_set_win = 1'b1;
              w_win_val = r_turn ? WIN_P2 : WIN_P1;
              w_nxt     = S_OVER;
            end else if (r_cnt == LP_CELLS) begin
              w_set_win = 1'b1;
              w_win_val = WIN_DRAW;
              w_nxt     = S_OVER;
            end else begin
              w_toggle = 1'b1;
              w_nxt    = S_IDLE;
            end
          end
        end
        S_OVER: w_nxt = S_OVER;
        S_CLEAR: begin
          if (clr_done) begin
            w_clr_fin = 1'b1;
            w_nxt     = S_IDLE;
          end
        end
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_turn      <= 1'b0;
      r_cnt       <= '0;
      r_win       <= WIN_NONE;
      r_chk_first <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_chk_first <= (r_state == S_WRITE);
      if (w_clr_fin) begin
        r_x    <= '0;
        r_y    <= '0;
        r_turn <= 1'b0;
        r_cnt  <= '0;
        r_win  <= WIN_NONE;
      end else begin
        if (w_step_x) r_x <= r_x + COORD_W'(1);
        if (w_step_y) r_y <= r_y + COORD_W'(1);
        if (w_inc) r_cnt <= r_cnt + CW'(1);
        if (w_toggle) r_turn <= ~r_turn;
        if (w_set_win) r_win <= w_win_val;
      end
    end
  end

  assign loca      = {r_y, r_x};
  assign rd_addr   = loca;
  assign wr_addr   = loca;
  assign wr_data   = stone(r_turn);
  assign clr_req   = (r_state == S_CLEAR);
  assign turn      = r_turn;
  assign winner    = r_win;
  assign game_over = (r_state == S_OVER);
  assign busy      = (r_state != S_IDLE) && (r_state != S_OVER);

endmodule

// File: tb/tb_fs_move_ctrl.sv
// Bench for fs_move_ctrl: board RAM model, directed and random moves,
// checked against a move-level reference of cursor, turn and outcome.
module tb_fs_move_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       btn_x, btn_y, btn_place, new_game;
  logic [7:0] loca, rd_addr, wr_addr;
  logic [1:0] rd_data, wr_data, winner;
  logic       wr_en, clr_req, clr_done;
  logic       chk_start, chk_done, chk_win;
  logic       turn, illegal, busy, game_over;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  int ref_x, ref_y, ref_cnt;
  bit ref_turn, ref_over;
  logic [1:0] ref_win;
  bit ref_occ [256];

  logic [1:0] ram [256];

  always #5 clk = ~clk;

  fs_move_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .btn_x     (btn_x),
    .btn_y     (btn_y),
    .btn_place (btn_place),
    .new_game  (new_game),
    .loca      (loca),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .clr_done  (clr_done),
    .chk_start (chk_start),
    .chk_done  (chk_done),
    .chk_win   (chk_win),
    .turn      (turn),
    .illegal   (illegal),
    .busy      (busy),
    .game_over (game_over),
    .winner    (winner)
  );

  always @(posedge clk) begin
    if (!resetn || (clr_req && clr_done)) begin
      for (int i = 0; i < 256; i++) ram[i] <= 2'b00;
      rd_data <= 2'b00;
    end else begin
      rd_data <= ram[rd_addr];
      if (wr_en) ram[wr_addr] <= wr_data;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_loca();
    return ref_y * 16 + ref_x;
  endfunction

  task automatic ref_reset();
    ref_x = 0; ref_y = 0; ref_cnt = 0;
    ref_turn = 0; ref_over = 0; ref_win = 2'b00;
    for (int i = 0; i < 256; i++) ref_occ[i] = 0;
  endtask

  task automatic press(input bit bx, input bit by);
    btn_x = bx; btn_y = by;
    @(negedge clk);
    btn_x = 0; btn_y = 0;
    @(negedge clk);
    if (!ref_over) begin
      if (bx) ref_x = (ref_x + 1) % 16;
      if (by) ref_y = (ref_y + 1) % 16;
    end
    check("loca", loca, exp_loca());
  endtask

  task automatic place(input bit win, input int lat);
    bit occ;
    int a;
    a = exp_loca();
    occ = ref_occ[a];
    btn_place = 1;
    @(negedge clk);
    btn_place = 0;
    @(negedge clk);
    check("busy_read", busy, 1);
    @(negedge clk);
    check("illegal_eval", illegal, occ);
    check("wr_en_eval", wr_en, 0);
    @(negedge clk);
    if (occ) begin
      check("illegal_once", illegal, 0);
      check("no_wr_ill", wr_en, 0);
      check("busy_after_ill", busy, 0);
      check("turn_ill", turn, ref_turn);
      return;
    end
    check("wr_en", wr_en, 1);
    check("wr_addr", wr_addr, a);
    check("wr_data", wr_data, ref_turn ? 2'b10 : 2'b01);
    @(negedge clk);
    check("chk_start", chk_start, 1);
    check("wr_en_once", wr_en, 0);
    ref_occ[a] = 1;
    ref_cnt++;
    repeat (lat) begin
      @(negedge clk);
      check("chk_start_once", chk_start, 0);
    end
    chk_done = 1; chk_win = win;
    @(negedge clk);
    chk_done = 0; chk_win = 0;
    if (win) begin
      ref_over = 1;
      ref_win = ref_turn ? 2'b10 : 2'b01;
    end else if (ref_cnt == 256) begin
      ref_over = 1;
      ref_win = 2'b11;
    end else begin
      ref_turn = ~ref_turn;
    end
    check("turn", turn, ref_turn);
    check("game_over", game_over, ref_over);
    check("winner", winner, ref_win);
    check("busy_done", busy, 0);
  endtask

  task automatic pulse_new_game();
    new_game = 1;
    @(negedge clk);
    new_game = 0;
    check("clr_req_on", clr_req, 1);
  endtask

  task automatic finish_clear();
    repeat (2) @(negedge clk);
    check("clr_req_hold", clr_req, 1);
    clr_done = 1;
    @(negedge clk);
    clr_done = 0;
    ref_reset();
    check("clr_loca", loca, 0);
    check("clr_turn", turn, 0);
    check("clr_winner", winner, 0);
    check("clr_req_off", clr_req, 0);
    check("clr_busy", busy, 0);
  endtask

  task automatic seek_empty();
    for (int i = 0; i < 300 && ref_occ[exp_loca()]; i++) begin
      if (ref_x == 15) press(1, 1);
      else press(1, 0);
    end
    check("seek_empty", ref_occ[exp_loca()], 0);
  endtask

  initial begin
    resetn = 0;
    btn_x = 0; btn_y = 0; btn_place = 0; new_game = 0;
    clr_done = 0; chk_done = 0; chk_win = 0;
    ref_reset();
    repeat (2) @(negedge clk);
    check("rst_loca", loca, 0);
    check("rst_turn", turn, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_chk_start", chk_start, 0);
    check("rst_clr_req", clr_req, 0);
    check("rst_illegal", illegal, 0);
    check("rst_busy", busy, 0);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);
    resetn = 1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) press(1, 0);
    for (int i = 0; i < 15; i++) press(0, 1);
    repeat (15) press(1, 0);
    check("at_ff", loca, 8'hFF);
    press(1, 1);
    check("wrap_00", loca, 8'h00);

    repeat (3) press(1, 0);
    repeat (2) press(0, 1);
    check("at_23", loca, 8'h23);
    place(0, 2);
    check("turn_p2", turn, 1);
    place(0, 1);
    press(1, 0);
    place(0, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: press(1, 0);
        1: press(0, 1);
        2: press(1, 1);
        default: place(0, $urandom_range(0, 3));
      endcase
    end

    seek_empty();
    if (!ref_turn) begin
      place(0, 1);
      seek_empty();
    end
    place(1, 3);
    check("win_p2", winner, 2'b10);
    press(1, 0);
    press(0, 1);
    btn_place = 1;
    @(negedge clk);
    btn_place = 0;
    repeat (2) @(negedge clk);
    check("over_busy", busy, 0);
    check("over_hold", game_over, 1);
    pulse_new_game();
    finish_clear();

    btn_place = 1;
    @(negedge clk);
    btn_place = 0;
    repeat (4) @(negedge clk);
    check("abort_chk_start", chk_start, 1);
    repeat (2) @(negedge clk);
    pulse_new_game();
    chk_done = 1; chk_win = 1;
    @(negedge clk);
    chk_done = 0; chk_win = 0;
    check("abort_clr", clr_req, 1);
    check("abort_winner", winner, 0);
    check("abort_over", game_over, 0);
    finish_clear();

    for (int i = 0; i < 256; i++) begin
      place(0, i % 3);
      if (i < 255) begin
        if (ref_x == 15) press(1, 1);
        else press(1, 0);
      end
    end
    check("draw", winner, 2'b11);
    check("draw_over", game_over, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
